// File: rtl/bmc_soft_pipe_if.sv
// Handshake and data bundle for the branch-metric unit.
// Demapper side: in_valid/in_ready/rx_sym/hard_mode (+ erase with BMC_ERASURE_EN).
// ACS side: out_valid/out_ready/bm_flat/min_idx.
interface bmc_soft_pipe_if #(
  parameter int N_OUT = 2,
  parameter int SW    = 3
);
  localparam int MW = SW + $clog2(N_OUT);
  localparam int NM = 1 << N_OUT;

  logic                  in_valid;
  logic                  in_ready;
  logic [N_OUT*SW-1:0]   rx_sym;
  logic                  hard_mode;
  logic                  out_valid;
  logic                  out_ready;
  logic [NM*MW-1:0]      bm_flat;
  logic [N_OUT-1:0]      min_idx;
`ifdef BMC_ERASURE_EN
  logic [N_OUT-1:0]      erase;

  modport master (output in_valid, rx_sym, hard_mode, erase, out_ready,
                  input  in_ready, out_valid, bm_flat, min_idx);
  modport slave  (input  in_valid, rx_sym, hard_mode, erase, out_ready,
                  output in_ready, out_valid, bm_flat, min_idx);
`else
  modport master (output in_valid, rx_sym, hard_mode, out_ready,
                  input  in_ready, out_valid, bm_flat, min_idx);
  modport slave  (input  in_valid, rx_sym, hard_mode, out_ready,
                  output in_ready, out_valid, bm_flat, min_idx);
`endif
endinterface

// File: rtl/bmc_soft_pipe.sv
// Pipelined branch-metric unit for the Viterbi decoder.
// S1 registers per-lane distances (hard/soft mode is folded into them),
// S2 registers all 2^N_OUT metrics plus the index of the smallest one.
// Optional macro BMC_ERASURE_EN adds a per-lane erase input (punctured codes).
module bmc_soft_pipe #(
  parameter int N_OUT = 2,
  parameter int SW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  bmc_soft_pipe_if.slave bus
);
  localparam int MW = SW + $clog2(N_OUT);
  localparam int NM = 1 << N_OUT;
  localparam logic [SW-1:0] SMAX = '1;

  logic [N_OUT-1:0] erase_w;
`ifdef BMC_ERASURE_EN
  assign erase_w = bus.erase;
`else
  assign erase_w = '0;
`endif

  logic                        s1_valid_q, s1_valid_d;
  logic [N_OUT-1:0][MW-1:0]    d0_q, d0_d, d1_q, d1_d;
  logic                        s2_valid_q, s2_valid_d;
  logic [NM-1:0][MW-1:0]       bm_q, bm_d, metric_w;
  logic [N_OUT-1:0]            min_q, min_d, best_w;
  logic                        s1_load, s2_load;
  logic [SW-1:0]               samp;
  logic [MW-1:0]               acc;
  logic [MW-1:0]               best_val;

  assign s2_load       = !s2_valid_q || bus.out_ready;
  assign s1_load       = !s1_valid_q || s2_load;
  assign bus.in_ready  = s1_load;
  assign bus.out_valid = s2_valid_q;
  assign bus.bm_flat   = bm_q;
  assign bus.min_idx   = min_q;

  // Stage 1: per-lane distance to a '0' (d0) and to a '1' (d1)
  always_comb begin
    s1_valid_d = s1_valid_q;
    d0_d       = d0_q;
    d1_d       = d1_q;
    samp       = '0;
    if (s1_load) begin
      s1_valid_d = bus.in_valid;
      if (bus.in_valid) begin
        for (int i = 0; i < N_OUT; i++) begin
          samp = bus.rx_sym[i*SW +: SW];
          if (erase_w[i]) begin
            d0_d[i] = '0;
            d1_d[i] = '0;
          end else if (bus.hard_mode) begin
            d0_d[i] = MW'(samp[SW-1]);
            d1_d[i] = MW'(!samp[SW-1]);
          end else begin
            d0_d[i] = MW'(samp);
            d1_d[i] = MW'(SMAX - samp);
          end
        end
      end
    end
  end

  // Stage 2 datapath: sum lane distances per hypothesis, pick lowest index of the minimum
  always_comb begin
    metric_w = '0;
    best_w   = '0;
    best_val = '1;
    acc      = '0;
    for (int j = 0; j < NM; j++) begin
      acc = '0;
      for (int i = 0; i < N_OUT; i++) begin
        acc = acc + ((((j >> i) & 1) != 0) ? d1_q[i] : d0_q[i]);
      end
      metric_w[j] = acc;
      // strict compare keeps the earlier index on ties; j==0 always seeds
      if (j == 0 || acc < best_val) begin
        best_val = acc;
        best_w   = N_OUT'(j);
      end
    end
  end

  // Stage 2 load control: capture S1 whenever the output slot is free or drained
  always_comb begin
    s2_valid_d = s2_valid_q;
    bm_d       = bm_q;
    min_d      = min_q;
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        bm_d  = metric_w;
        min_d = best_w;
      end
    end
  end

  // Pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      d0_q       <= '0;
      d1_q       <= '0;
      s2_valid_q <= 1'b0;
      bm_q       <= '0;
      min_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      d0_q       <= d0_d;
      d1_q       <= d1_d;
      s2_valid_q <= s2_valid_d;
      bm_q       <= bm_d;
      min_q      <= min_d;
    end
  end
endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Self-checking bench for bmc_soft_pipe (N_OUT=2, SW=3).
module tb_bmc_soft_pipe;
  localparam int N  = 2;
  localparam int SW = 3;
  localparam int MW = SW + $clog2(N);
  localparam int NM = 1 << N;
  localparam int RW = N + NM*MW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bmc_soft_pipe_if #(.N_OUT(N), .SW(SW)) bif();
  bmc_soft_pipe #(.N_OUT(N), .SW(SW)) dut (.clk(clk), .rst_n(rst_n), .bus(bif.slave));

  logic [N-1:0] erase_v = '0;
`ifdef BMC_ERASURE_EN
  assign bif.erase = erase_v;
`endif

  int total = 0;
  int bad   = 0;

  // Reference: soft distance is the sample (to '0') or its complement (to '1');
  // hard distance is a Hamming bit on the sample MSB; erased lanes add nothing.
  function automatic logic [RW-1:0] ref_res(input logic [N*SW-1:0] sym,
                                            input logic hard,
                                            input logic [N-1:0] er);
    logic [NM*MW-1:0] bm;
    int m, best, bestv, s, maxv, h, b;
    maxv  = (1 << SW) - 1;
    bm    = '0;
    best  = 0;
    bestv = 1 << 30;
    for (int j = 0; j < NM; j++) begin
      m = 0;
      for (int i = 0; i < N; i++) begin
        if (!er[i]) begin
          s = int'(sym[i*SW +: SW]);
          b = (j >> i) & 1;
          if (hard) begin
            h = (s >= (1 << (SW-1))) ? 1 : 0;
            m += (h == b) ? 0 : 1;
          end else begin
            m += (b == 1) ? (maxv - s) : s;
          end
        end
      end
      bm[j*MW +: MW] = MW'(m);
      if (m < bestv) begin
        bestv = m;
        best  = j;
      end
    end
    return {N'(best), bm};
  endfunction

  task automatic drive(input logic v, input logic [N*SW-1:0] sym,
                       input logic hard, input logic ordy);
    @(negedge clk);
    bif.in_valid  = v;
    bif.rx_sym    = sym;
    bif.hard_mode = hard;
    bif.out_ready = ordy;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bif.in_valid = 1'b0; bif.rx_sym = '0; bif.hard_mode = 1'b0; bif.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    total++; if (bif.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bif.out_valid); end
    total++; if (bif.bm_flat !== '0) begin bad++; $display("FAIL reset_bm: got %h want 0", bif.bm_flat); end
    total++; if (bif.min_idx !== '0) begin bad++; $display("FAIL reset_min: got %h want 0", bif.min_idx); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (bif.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bif.in_ready); end
  endtask

  // One symbol at a time, out_ready=1: valid exactly two cycles after the handshake
  task automatic run_single(input string nm, input logic [N*SW-1:0] sym,
                            input logic hard, input logic [RW-1:0] want);
    drive(1'b1, sym, hard, 1'b1);
    drive(1'b0, '0, 1'b0, 1'b1);
    total++; if (bif.out_valid !== 1'b0) begin bad++; $display("FAIL %s_early: out_valid got %b want 0", nm, bif.out_valid); end
    drive(1'b0, '0, 1'b0, 1'b1);
    total++; if (bif.out_valid !== 1'b1) begin bad++; $display("FAIL %s_latency: out_valid got %b want 1", nm, bif.out_valid); end
    total++; if ({bif.min_idx, bif.bm_flat} !== want) begin bad++; $display("FAIL %s: got %h want %h", nm, {bif.min_idx, bif.bm_flat}, want); end
    drive(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_metrics();
    erase_v = '0;
    run_single("soft_7_0",  {3'd0, 3'd7}, 1'b0, {2'd1, 4'd7, 4'd14, 4'd0, 4'd7});
    run_single("hard_5_2",  {3'd2, 3'd5}, 1'b1, {2'd1, 4'd1, 4'd2,  4'd0, 4'd1});
    run_single("soft_4_4",  {3'd4, 3'd4}, 1'b0, {2'd3, 4'd6, 4'd7,  4'd7, 4'd8});
    run_single("soft_3_3",  {3'd3, 3'd3}, 1'b0, {2'd0, 4'd8, 4'd7,  4'd7, 4'd6});
    run_single("soft_7_7",  {3'd7, 3'd7}, 1'b0, {2'd3, 4'd0, 4'd7,  4'd7, 4'd14});
    run_single("hard_4_3",  {3'd3, 3'd4}, 1'b1, {2'd1, 4'd1, 4'd2,  4'd0, 4'd1});
  endtask

`ifdef BMC_ERASURE_EN
  task automatic test_erasure();
    erase_v = 2'b01;
    run_single("erase_01", {3'd0, 3'd7}, 1'b0, {2'd0, 4'd7, 4'd7, 4'd0, 4'd0});
    erase_v = 2'b11;
    run_single("erase_11", {3'd2, 3'd5}, 1'b0, {2'd0, 4'd0, 4'd0, 4'd0, 4'd0});
    erase_v = 2'b10;
    run_single("erase_10h", {3'd7, 3'd5}, 1'b1, {2'd1, 4'd0, 4'd1, 4'd0, 4'd1});
    erase_v = '0;
  endtask
`endif

  // Streaming scoreboard. mode 0: full rate; 1: fixed out_ready pattern,
  // alternating hard_mode; 2: random valid/ready/mode/erase.
  task automatic run_stream(input string nm, input int mode, input int n);
    logic [RW-1:0] exp_q[$];
    int            acc_q[$];
    int            pat[8] = '{1, 0, 0, 1, 0, 1, 1, 1};
    int            cyc, sent, limit;
    logic          v, hard, ordy, exp_rdy, exp_ov, prev_stall;
    logic [N*SW-1:0] sym;
    logic [RW-1:0] prev_res;
    cyc = 0; sent = 0; prev_stall = 1'b0; prev_res = '0;
    limit = n*12 + 40;
    while ((sent < n || exp_q.size() > 0) && cyc < limit) begin
      sym  = (N*SW)'($urandom);
      hard = 1'b0;
      case (mode)
        0: begin v = (sent < n); ordy = 1'b1; hard = 1'($urandom); end
        1: begin v = (sent < n); ordy = pat[cyc % 8][0]; hard = sent[0]; end
        default: begin
          v = (sent < n) && ($urandom_range(0, 3) != 0);
          ordy = ($urandom_range(0, 2) != 0);
          hard = 1'($urandom);
`ifdef BMC_ERASURE_EN
          erase_v = N'($urandom);
`endif
        end
      endcase
      drive(v, sym, hard, ordy);
      exp_rdy = !(exp_q.size() == 2 && !ordy);
      exp_ov  = (exp_q.size() > 0) && (cyc - acc_q[0] >= 2);
      total++; if (bif.in_ready !== exp_rdy) begin bad++; $display("FAIL %s_in_ready c%0d: got %b want %b", nm, cyc, bif.in_ready, exp_rdy); end
      total++; if (bif.out_valid !== exp_ov) begin bad++; $display("FAIL %s_out_valid c%0d: got %b want %b", nm, cyc, bif.out_valid, exp_ov); end
      if (prev_stall) begin
        total++; if ({bif.min_idx, bif.bm_flat} !== prev_res) begin bad++; $display("FAIL %s_stall_hold c%0d: got %h want %h", nm, cyc, {bif.min_idx, bif.bm_flat}, prev_res); end
      end
      if (bif.out_valid === 1'b1 && exp_ov) begin
        total++; if ({bif.min_idx, bif.bm_flat} !== exp_q[0]) begin bad++; $display("FAIL %s_data c%0d: got %h want %h", nm, cyc, {bif.min_idx, bif.bm_flat}, exp_q[0]); end
      end
      if (bif.out_valid === 1'b1 && ordy && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(acc_q.pop_front());
      end
      if (v && bif.in_ready === 1'b1) begin
        exp_q.push_back(ref_res(sym, hard, erase_v));
        acc_q.push_back(cyc);
        sent++;
      end
      prev_stall = (bif.out_valid === 1'b1) && !ordy;
      prev_res   = {bif.min_idx, bif.bm_flat};
      cyc++;
    end
    total++;
    if (sent != n || exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_complete: sent %0d pending %0d want sent %0d pending 0", nm, sent, exp_q.size(), n);
    end
    erase_v = '0;
    drive(1'b0, '0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_stream("b2b", 0, 20);
  endtask

  task automatic test_backpressure();
    run_stream("bp", 1, 6);
  endtask

  task automatic test_random();
    run_stream("rand", 2, 150);
  endtask

  task automatic test_midreset();
    drive(1'b1, (N*SW)'($urandom), 1'b0, 1'b0);
    drive(1'b1, (N*SW)'($urandom), 1'b1, 1'b0);
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bif.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %b want 0", bif.out_valid); end
    total++; if (bif.bm_flat !== '0) begin bad++; $display("FAIL midrst_bm: got %h want 0", bif.bm_flat); end
    total++; if (bif.min_idx !== '0) begin bad++; $display("FAIL midrst_min: got %h want 0", bif.min_idx); end
    @(negedge clk);
    rst_n = 1'b1;
    bif.out_ready = 1'b1;
    #1;
    total++; if (bif.in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready: got %b want 1", bif.in_ready); end
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, '0, 1'b0, 1'b1);
      total++; if (bif.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_stale c%0d: got %b want 0", k, bif.out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_metrics();
`ifdef BMC_ERASURE_EN
    test_erasure();
`endif
    test_back_to_back();
    test_backpressure();
    test_random();
    test_midreset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
